// File: rtl/timer_pkg.sv
// Shared types, glyph codes and BCD helpers for the irrigation countdown timer.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [3:0] CODE_R = 4'b1011;
  localparam logic [3:0] CODE_r = 4'b1100;
  localparam logic [3:0] CODE_o = 4'b1101;
  localparam logic [3:0] CODE_A = 4'b1110;
  localparam logic [3:0] CODE_F = 4'b1111;

  // Debug view of the controller: FSM state and the mm:ss BCD count.
  typedef struct packed {
    state_t      state;
    logic [15:0] count;
  } timer_dbg_t;

  function automatic logic bcd_valid(input logic [7:0] mm, input logic [7:0] ss);
    return (mm[7:4] <= 4'd9) && (mm[3:0] <= 4'd9) &&
           (ss[7:4] <= 4'd5) && (ss[3:0] <= 4'd9);
  endfunction

  // One-second BCD decrement of {mm_t, mm_o, ss_t, ss_o}; caller guarantees count != 0.
  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) begin
      r[3:0] = c[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) begin
        r[7:4] = c[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (c[11:8] != 4'd0) begin
          r[11:8] = c[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = c[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/display_scan_mux.sv
// Four-digit time-multiplexer: free-running scan divider, digit index and
// registered data/select outputs that always change together.
module display_scan_mux #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] digits,
  output logic [3:0]  data,
  output logic [3:0]  digit_sel_n
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic          adv;

  assign adv      = (div_cnt == DW'(SCAN_DIV - 1));
  assign next_idx = adv ? idx + 2'd1 : idx;

  // data and select are both derived from next_idx so they never skew.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      idx         <= 2'd0;
      data        <= 4'b0000;
      digit_sel_n <= 4'b1110;
    end else begin
      div_cnt     <= adv ? '0 : div_cnt + DW'(1);
      idx         <= next_idx;
      digit_sel_n <= ~(4'b0001 << next_idx);
      data        <= digits[{next_idx, 2'b00} +: 4];
    end
  end

endmodule

// File: rtl/irrigation_countdown_display.sv
// Irrigation countdown: mm:ss BCD down-counter with run/pause/done/error FSM,
// one-second prescaler and a multiplexed digit output for the 7-segment decoder.
module irrigation_countdown_display
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       fault,
  output logic       valve_on,
  output logic       done,
  output logic       error,
  output logic [3:0] data,
  output logic [3:0] digit_sel_n,
  output timer_dbg_t dbg
);

  localparam int PW = $clog2(TICK_DIV);

  state_t        state;
  logic [15:0]   count;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [15:0]   next_count;
  logic [15:0]   digit_word;

  assign tick       = (prescaler == PW'(TICK_DIV - 1));
  assign next_count = bcd_dec(count);
  assign dbg        = '{state: state, count: count};

  // Priority: fault > clear > load > start > stop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 16'h0000;
      prescaler <= '0;
      valve_on  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fault) begin
        state    <= ERROR;
        valve_on <= 1'b0;
        error    <= 1'b1;
      end else if (clear) begin
        state     <= IDLE;
        count     <= 16'h0000;
        prescaler <= '0;
        valve_on  <= 1'b0;
        error     <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (load) begin
              if (bcd_valid(load_mm, load_ss)) begin
                state <= IDLE;
                count <= {load_mm, load_ss};
              end else begin
                state <= ERROR;
                error <= 1'b1;
              end
            end else if (start && (count != 16'h0000)) begin
              state     <= RUN;
              prescaler <= '0;
              valve_on  <= 1'b1;
            end
          end
          PAUSE: begin
            // Resume keeps the held prescaler phase.
            if (start && (count != 16'h0000)) begin
              state    <= RUN;
              valve_on <= 1'b1;
            end
          end
          RUN: begin
            if (tick) begin
              prescaler <= '0;
              count     <= next_count;
              if (next_count == 16'h0000) begin
                state    <= DONE;
                done     <= 1'b1;
                valve_on <= 1'b0;
              end else if (stop && !start) begin
                state    <= PAUSE;
                valve_on <= 1'b0;
              end
            end else begin
              prescaler <= prescaler + PW'(1);
              if (stop && !start) begin
                state    <= PAUSE;
                valve_on <= 1'b0;
              end
            end
          end
          ERROR: begin
            state <= ERROR;
          end
          default: begin
            state    <= IDLE;
            valve_on <= 1'b0;
          end
        endcase
      end
    end
  end

  assign digit_word = (state == ERROR) ? {CODE_R, CODE_r, CODE_r, CODE_o} : count;

  display_scan_mux #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clock       (clock),
    .reset       (reset),
    .digits      (digit_word),
    .data        (data),
    .digit_sel_n (digit_sel_n)
  );

endmodule

// File: tb/tb_irrigation_countdown_display.sv
// Directed bench for irrigation_countdown_display with TICK_DIV=10, SCAN_DIV=2.
module tb_irrigation_countdown_display;
  import timer_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_mm = 8'h00;
  logic [7:0] load_ss = 8'h00;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       fault = 1'b0;
  logic       valve_on;
  logic       done;
  logic       error;
  logic [3:0] data;
  logic [3:0] digit_sel_n;
  timer_dbg_t dbg;

  int total = 0;
  int bad = 0;

  irrigation_countdown_display #(
    .TICK_DIV(10),
    .SCAN_DIV(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_mm     (load_mm),
    .load_ss     (load_ss),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .fault       (fault),
    .valve_on    (valve_on),
    .done        (done),
    .error       (error),
    .data        (data),
    .digit_sel_n (digit_sel_n),
    .dbg         (dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
    load_mm = mm;
    load_ss = ss;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    total++; if (valve_on !== 1'b0) begin bad++; $display("FAIL rst_valve: got %b want 0", valve_on); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", error); end
    total++; if (data !== 4'b0000) begin bad++; $display("FAIL rst_data: got %b want 0000", data); end
    total++; if (digit_sel_n !== 4'b1110) begin bad++; $display("FAIL rst_sel: got %b want 1110", digit_sel_n); end
    total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", dbg.state, IDLE); end
    total++; if (dbg.count !== 16'h0000) begin bad++; $display("FAIL rst_count: got %h want 0000", dbg.count); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_countdown();
    do_load(8'h00, 8'h03);
    total++; if (dbg.count !== 16'h0003) begin bad++; $display("FAIL cd_load: got %h want 0003", dbg.count); end
    do_start();
    total++; if (valve_on !== 1'b1) begin bad++; $display("FAIL cd_valve_on: got %b want 1", valve_on); end
    total++; if (dbg.state !== RUN) begin bad++; $display("FAIL cd_state_run: got %0d want %0d", dbg.state, RUN); end
    cyc(9);
    total++; if (dbg.count !== 16'h0003) begin bad++; $display("FAIL cd_hold9: got %h want 0003", dbg.count); end
    cyc(1);
    total++; if (dbg.count !== 16'h0002) begin bad++; $display("FAIL cd_t10: got %h want 0002", dbg.count); end
    cyc(10);
    total++; if (dbg.count !== 16'h0001) begin bad++; $display("FAIL cd_t20: got %h want 0001", dbg.count); end
    cyc(9);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL cd_done_early: got %b want 0", done); end
    // stop lands on the final tick edge: the decrement and DONE must win
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    total++; if (dbg.count !== 16'h0000) begin bad++; $display("FAIL cd_t30: got %h want 0000", dbg.count); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL cd_done_pulse: got %b want 1", done); end
    total++; if (valve_on !== 1'b0) begin bad++; $display("FAIL cd_valve_off: got %b want 0", valve_on); end
    total++; if (dbg.state !== DONE) begin bad++; $display("FAIL cd_state_done: got %0d want %0d", dbg.state, DONE); end
    cyc(1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL cd_done_width: got %b want 0", done); end
  endtask

  task automatic test_borrow();
    logic [3:0] seen;
    logic [3:0] exp_d;
    do_load(8'h01, 8'h00);
    total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL br_load_from_done: got %0d want %0d", dbg.state, IDLE); end
    do_start();
    cyc(10);
    total++; if (dbg.count !== 16'h0059) begin bad++; $display("FAIL br_0100: got %h want 0059", dbg.count); end
    do_clear();
    total++; if (dbg.count !== 16'h0000) begin bad++; $display("FAIL br_clear: got %h want 0000", dbg.count); end
    do_load(8'h10, 8'h00);
    do_start();
    cyc(10);
    total++; if (dbg.count !== 16'h0959) begin bad++; $display("FAIL br_1000: got %h want 0959", dbg.count); end
    do_load(8'h00, 8'h11);
    total++; if (dbg.count !== 16'h0959) begin bad++; $display("FAIL br_load_in_run: got %h want 0959", dbg.count); end
    total++; if (dbg.state !== RUN) begin bad++; $display("FAIL br_run_kept: got %0d want %0d", dbg.state, RUN); end
    seen = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      case (digit_sel_n)
        4'b1110: begin exp_d = 4'h9; seen[0] = 1'b1; end
        4'b1101: begin exp_d = 4'h5; seen[1] = 1'b1; end
        4'b1011: begin exp_d = 4'h9; seen[2] = 1'b1; end
        4'b0111: begin exp_d = 4'h0; seen[3] = 1'b1; end
        default: exp_d = 4'hx;
      endcase
      total++; if (data !== exp_d) begin bad++; $display("FAIL br_scan_data: sel %b got %b want %b", digit_sel_n, data, exp_d); end
    end
    total++; if (seen !== 4'b1111) begin bad++; $display("FAIL br_scan_cover: got %b want 1111", seen); end
    do_clear();
  endtask

  task automatic test_pause();
    do_load(8'h00, 8'h05);
    do_start();
    cyc(3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    total++; if (dbg.state !== PAUSE) begin bad++; $display("FAIL pa_state: got %0d want %0d", dbg.state, PAUSE); end
    total++; if (valve_on !== 1'b0) begin bad++; $display("FAIL pa_valve: got %b want 0", valve_on); end
    cyc(50);
    total++; if (dbg.count !== 16'h0005) begin bad++; $display("FAIL pa_hold: got %h want 0005", dbg.count); end
    // start and stop together: start wins
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    total++; if (dbg.state !== RUN) begin bad++; $display("FAIL pa_resume: got %0d want %0d", dbg.state, RUN); end
    cyc(5);
    total++; if (dbg.count !== 16'h0005) begin bad++; $display("FAIL pa_r5: got %h want 0005", dbg.count); end
    cyc(1);
    total++; if (dbg.count !== 16'h0004) begin bad++; $display("FAIL pa_r6: got %h want 0004", dbg.count); end
    do_clear();
  endtask

  task automatic test_invalid_load();
    logic [3:0] seen;
    logic [3:0] exp_d;
    logic [3:0] prev_sel;
    logic [3:0] exp_sel;
    do_load(8'h12, 8'h60);
    total++; if (dbg.state !== ERROR) begin bad++; $display("FAIL iv_state: got %0d want %0d", dbg.state, ERROR); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL iv_error: got %b want 1", error); end
    cyc(1);
    seen = 4'b0000;
    prev_sel = digit_sel_n;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      case (digit_sel_n)
        4'b1110: begin exp_d = 4'b1101; seen[0] = 1'b1; end
        4'b1101: begin exp_d = 4'b1100; seen[1] = 1'b1; end
        4'b1011: begin exp_d = 4'b1100; seen[2] = 1'b1; end
        4'b0111: begin exp_d = 4'b1011; seen[3] = 1'b1; end
        default: exp_d = 4'hx;
      endcase
      total++; if (data !== exp_d) begin bad++; $display("FAIL iv_scan_data: sel %b got %b want %b", digit_sel_n, data, exp_d); end
      if (digit_sel_n != prev_sel) begin
        exp_sel = {prev_sel[2:0], prev_sel[3]};
        total++; if (digit_sel_n !== exp_sel) begin bad++; $display("FAIL iv_scan_order: got %b want %b", digit_sel_n, exp_sel); end
      end
      prev_sel = digit_sel_n;
    end
    total++; if (seen !== 4'b1111) begin bad++; $display("FAIL iv_scan_cover: got %b want 1111", seen); end
    do_clear();
    total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL iv_clear_state: got %0d want %0d", dbg.state, IDLE); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL iv_clear_error: got %b want 0", error); end
    do_load(8'h1A, 8'h00);
    total++; if (dbg.state !== ERROR) begin bad++; $display("FAIL iv_nibble: got %0d want %0d", dbg.state, ERROR); end
    do_clear();
    do_load(8'h99, 8'h59);
    total++; if (dbg.count !== 16'h9959) begin bad++; $display("FAIL iv_max_ok: got %h want 9959", dbg.count); end
    total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL iv_max_state: got %0d want %0d", dbg.state, IDLE); end
    do_clear();
  endtask

  task automatic test_fault();
    do_load(8'h00, 8'h09);
    do_start();
    cyc(20);
    total++; if (dbg.count !== 16'h0007) begin bad++; $display("FAIL ft_at7: got %h want 0007", dbg.count); end
    fault = 1'b1;
    cyc(1);
    total++; if (dbg.state !== ERROR) begin bad++; $display("FAIL ft_state: got %0d want %0d", dbg.state, ERROR); end
    total++; if (valve_on !== 1'b0) begin bad++; $display("FAIL ft_valve: got %b want 0", valve_on); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL ft_error: got %b want 1", error); end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    total++; if (dbg.state !== ERROR) begin bad++; $display("FAIL ft_clear_blocked: got %0d want %0d", dbg.state, ERROR); end
    fault = 1'b0;
    cyc(1);
    total++; if (dbg.state !== ERROR) begin bad++; $display("FAIL ft_sticky: got %0d want %0d", dbg.state, ERROR); end
    do_clear();
    total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL ft_recover: got %0d want %0d", dbg.state, IDLE); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL ft_error_clr: got %b want 0", error); end
  endtask

  task automatic test_reset_mid_run();
    do_load(8'h00, 8'h04);
    do_start();
    cyc(5);
    total++; if (valve_on !== 1'b1) begin bad++; $display("FAIL mr_running: got %b want 1", valve_on); end
    reset = 1'b1;
    #1;
    total++; if (valve_on !== 1'b0) begin bad++; $display("FAIL mr_valve: got %b want 0", valve_on); end
    total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL mr_state: got %0d want %0d", dbg.state, IDLE); end
    total++; if (dbg.count !== 16'h0000) begin bad++; $display("FAIL mr_count: got %h want 0000", dbg.count); end
    total++; if (digit_sel_n !== 4'b1110) begin bad++; $display("FAIL mr_sel: got %b want 1110", digit_sel_n); end
    total++; if (data !== 4'b0000) begin bad++; $display("FAIL mr_data: got %b want 0000", data); end
    cyc(1);
    reset = 1'b0;
    do_start();
    total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL mr_start_zero: got %0d want %0d", dbg.state, IDLE); end
    total++; if (valve_on !== 1'b0) begin bad++; $display("FAIL mr_start_valve: got %b want 0", valve_on); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_invalid_load();
    test_fault();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
